// File: rtl/transaction_rr_arbiter.sv
// Transaction-layer arbiter/router: pops one word per cycle from NUM_CH input FIFOs and routes it by destination field.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; otherwise the grant is fixed priority with the lowest index first.
module transaction_rr_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int WORD_SIZE = 10,
   parameter int DEST_W    = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUM_CH-1:0]           in_empty,
   input  logic [NUM_CH*WORD_SIZE-1:0] in_data,
   input  logic [NUM_CH-1:0]           out_almost_full,
   output logic [NUM_CH-1:0]           in_pop,
   output logic [NUM_CH-1:0]           out_push,
   output logic [WORD_SIZE-1:0]        out_data,
   output logic [DEST_W-1:0]           grant_idx,
   output logic                        busy
);

   logic [NUM_CH-1:0]    eligible;
   logic                 issue_ok;
   logic                 grant_found;
   logic [DEST_W-1:0]    grant_sel;
   logic [NUM_CH-1:0]    pop_vec;
   logic                 s1_valid;
   logic [DEST_W-1:0]    s1_idx;
   logic [WORD_SIZE-1:0] s1_word;
   logic [NUM_CH-1:0]    push_vec;

   // A channel popped at the last edge is locked out: its empty flag has not caught up yet.
   assign eligible = ~in_empty & ~in_pop;
   assign issue_ok = enable & ~(|out_almost_full);

`ifdef ARB_ROUND_ROBIN_EN
   logic [DEST_W-1:0] rr_ptr;
   logic [DEST_W-1:0] cand;

   // Power-of-two channel count lets the DEST_W-bit add wrap past NUM_CH-1 back to 0.
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = '0;
      cand        = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         cand = rr_ptr + DEST_W'(j);
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_sel   = cand;
         end
      end
   end
`else
   // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_sel   = '0;
      for (int j = NUM_CH - 1; j >= 0; j--) begin
         if (eligible[j]) begin
            grant_found = 1'b1;
            grant_sel   = DEST_W'(j);
         end
      end
   end
`endif

   always_comb begin
      pop_vec            = '0;
      pop_vec[grant_sel] = 1'b1;
   end

   always_comb begin
      s1_word = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (s1_idx == DEST_W'(i)) s1_word = in_data[i*WORD_SIZE +: WORD_SIZE];
      end
   end

   always_comb begin
      push_vec                                   = '0;
      push_vec[s1_word[WORD_SIZE-1 -: DEST_W]]   = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_pop    <= '0;
         grant_idx <= '0;
         s1_valid  <= 1'b0;
         s1_idx    <= '0;
         out_push  <= '0;
         out_data  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_ptr    <= '0;
`endif
      end else begin
         in_pop <= '0;
         if (issue_ok && grant_found) begin
            in_pop    <= pop_vec;
            grant_idx <= grant_sel;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= grant_sel + DEST_W'(1);
`endif
         end
         // S1: the FIFO presents the popped word during the following cycle.
         s1_valid <= |in_pop;
         s1_idx   <= grant_idx;
         out_push <= '0;
         if (s1_valid) begin
            out_data <= s1_word;
            out_push <= push_vec;
         end
      end
   end

   assign busy = (|in_pop) | s1_valid | (|out_push);

endmodule

// File: doc/transaction_rr_arbiter.md
# transaction_rr_arbiter

Parametrised arbiter/router for the transaction layer. It sits between NUM_CH input FIFOs and NUM_CH output FIFOs. It pops one word per cycle from a non-empty input FIFO and pushes that word into the output FIFO selected by the word's destination field. It stalls new pops while any output FIFO reports almost-full, and it replaces the fixed 4-channel arbiter.

## Interface
- NUM_CH, 4, number of input and output channels (≥2, power of 2)
- WORD_SIZE, 10, FIFO word width including the destination field
- DEST_W, $clog2(NUM_CH), destination field width; the field is word[WORD_SIZE-1 -: DEST_W]

- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  from the FSM active state; when low, no new pops are issued
- in_empty  input  NUM_CH  empty flags of the input FIFOs
- in_data  input  NUM_CH*WORD_SIZE  flattened registered data_out of the input FIFOs; channel i is at [i*WORD_SIZE +: WORD_SIZE]
- out_almost_full  input  NUM_CH  almost-full flags of the output FIFOs
- in_pop  output  NUM_CH  one-hot pop to the input FIFOs, registered
- out_push  output  NUM_CH  one-hot push to the output FIFOs, registered
- out_data  output  WORD_SIZE  word to the output FIFOs, registered, shared by all channels
- grant_idx  output  DEST_W  last granted input channel
- busy  output  1  high while any word is in flight (pop issued, push not yet done)

## Operation
- Eligible channel: in_empty[i]=0 and channel i was not popped at the previous edge. This one-cycle lockout covers the empty-flag update lag.
- Issue condition: enable=1, reset=0, no out_almost_full bit set, at least one channel eligible.
- Pipeline, 3 stages:
  - S0: grant and register in_pop.
  - S1: the FIFO presents the word; register the granted index.
  - S2: register out_data = word and out_push = onehot(word dest field).
- Stall: when any out_almost_full is set, no new pops are issued. Words already in S1/S2 still complete. Output FIFO thresholds must leave ≥2 free slots.
- enable falling: same as a stall; in-flight words drain.
- in_pop and out_push are never asserted for a word not yet accepted. out_data keeps its last value when out_push=0.
- Routing:
  - The destination field selects the output channel. Payload bits pass through unchanged.
  - Multiple input channels targeting the same output are serialised, one push per cycle.

## Timing
- Reset values: in_pop=0, out_push=0, out_data=0, grant_idx=0, busy=0. The RR pointer resets to 0 and the lockout mask is cleared.
- Latency: in_pop asserted after edge k leads to out_push after edge k+2.
- Throughput: 1 word/cycle when ≥2 channels are eligible. A single non-empty channel gets 1 word every 2 cycles.
- Reset mid-operation: in-flight words are discarded. All outputs take reset values at the next edge, and no push occurs for popped words.
- Simultaneous almost_full rise and grant at the same edge: the stall wins and no pop is issued.
- grant_idx updates at the same edge as in_pop.
- busy = S0 or S1 valid, or S2 push pending.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Round-robin grant.
  - Search starts at (grant_idx+1) mod NUM_CH and wraps past NUM_CH-1 to 0.
  - The pointer advances only on a grant.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest eligible index wins.
  - A continuously non-empty channel 0 still yields every other cycle because of the lockout.

## Test plan
- Reset then single word, ARB_ROUND_ROBIN_EN defined, NUM_CH=4, WORD_SIZE=10: push 10'h278 into in FIFO 0, enable=1 -> in_pop=4'b0001 at edge k; out_push=4'b0100 with out_data=10'h278 at edge k+2; busy falls after.
- Four channels loaded 10'h0A6, 10'h145, 10'h278, 10'h389 (RR mode) -> pops in order ch0, ch1, ch2, ch3 on consecutive cycles; pushes 4'b0001, 4'b0010, 4'b0100, 4'b1000 on consecutive cycles, 2 cycles later.
- out_almost_full[0]=1 raised with 3 words queued -> in_pop stays 0 after the current edge; at most 2 in-flight pushes complete; popping resumes the cycle after almost_full falls.
- Fixed-priority build, ch0 and ch2 each hold 3 words -> grant sequence 0,2,0,2,0,2; ch0 is never granted on consecutive edges.
- Reset asserted one cycle after a pop of 10'h3A6 -> no out_push for that word; all outputs 0 at the next edge; the RR pointer returns to 0.
- Same-destination merge: ch1=10'h0A6 and ch3=10'h0A6 simultaneously -> two out_push=4'b0001 on consecutive cycles; word order follows grant order.
